// File: rtl/adc_spi_reader_pkg.sv
// adc_spi_reader_pkg: state type and SPI edge-select helper shared by the reader files
package adc_spi_reader_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_SHIFT, ST_DONE} state_t;

    // A leading edge captures miso in CPHA=0, a trailing edge captures it in CPHA=1.
    function automatic logic is_sample_edge(input logic phase, input logic leading);
        return leading ^ phase;
    endfunction

endpackage

// File: rtl/adc_spi_reader_rx.sv
// adc_spi_reader_rx: sck generator and receive shift register, started and stopped by the reader FSM
module adc_spi_reader_rx
    import adc_spi_reader_pkg::*;
#(
    parameter int WID             = 18,
    parameter int WID_LEN         = 5,
    parameter int POLARITY        = 1,
    parameter int PHASE           = 0,
    parameter int CYCLE_HALF_WAIT = 1,
    parameter int TIMER_WID       = 8
) (
    input  logic           clk,
    input  logic           rst_L,
    input  logic           i_start,
    input  logic           i_abort,
    input  logic           i_miso,
    output logic           o_sck,
    output logic           o_done,
    output logic [WID-1:0] o_data
);

    localparam logic [WID_LEN:0]     EDGES     = (WID_LEN+1)'(2 * WID);
    localparam logic [TIMER_WID-1:0] HALF_LAST = TIMER_WID'(CYCLE_HALF_WAIT - 1);
    localparam logic                 IDLE_LVL  = 1'(POLARITY);

    logic                 r_active;
    logic                 r_sck;
    logic [WID_LEN:0]     r_edge;
    logic [TIMER_WID-1:0] r_half;
    logic [WID-1:0]       r_shift;
    logic                 w_tick;
    logic                 w_edge;
    logic                 w_sample;

    // r_edge holds the number of edges already produced, so an even count means the next edge leads
    assign w_tick   = r_active && (r_half == HALF_LAST);
    assign o_done   = w_tick && (r_edge == EDGES);
    assign w_edge   = i_start || w_tick;
    assign w_sample = is_sample_edge(1'(PHASE), !r_edge[0]);
    assign o_sck    = r_sck;
    assign o_data   = r_shift;

    // Produce 2*WID sck edges one half-period apart, then hold idle for one half-period before done
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_active <= 1'b0;
            r_sck    <= IDLE_LVL;
            r_edge   <= '0;
            r_half   <= '0;
            r_shift  <= '0;
        end else if (i_abort || o_done) begin
            r_active <= 1'b0;
            r_sck    <= IDLE_LVL;
            r_edge   <= '0;
            r_half   <= '0;
        end else if (w_edge) begin
            r_active <= 1'b1;
            r_sck    <= ~r_sck;
            r_edge   <= r_edge + 1'b1;
            r_half   <= '0;
            if (w_sample) r_shift <= {r_shift[WID-2:0], i_miso};
        end else if (r_active) begin
            r_half   <= r_half + 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: one ADC convert-and-read per arm request over an SPI master receive path
module adc_spi_reader
    import adc_spi_reader_pkg::*;
#(
    parameter int WID             = 18,
    parameter int WID_LEN         = 5,
    parameter int POLARITY        = 1,
    parameter int PHASE           = 0,
    parameter int CYCLE_HALF_WAIT = 1,
    parameter int TIMER_WID       = 8,
    parameter int CONV_WAIT       = 150
) (
    input  logic           clk,
    input  logic           rst_L,
    input  logic           arm,
    output logic           finished,
    output logic [WID-1:0] data,
    output logic           busy,
    input  logic           miso,
    output logic           sck,
    output logic           ss_L
);

    localparam logic [TIMER_WID-1:0] CONV_LAST = TIMER_WID'(CONV_WAIT - 1);

    state_t               r_state;
    logic [TIMER_WID-1:0] r_timer;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_done;
    logic [WID-1:0]       w_shift;

    // The first sck edge lands exactly CONV_WAIT clocks after ss_L falls
    assign w_start = (r_state == ST_CONVERT) && arm && (r_timer == CONV_LAST);
    assign w_abort = ((r_state == ST_CONVERT) || (r_state == ST_SHIFT)) && !arm;

    adc_spi_reader_rx #(
        .WID             (WID),
        .WID_LEN         (WID_LEN),
        .POLARITY        (POLARITY),
        .PHASE           (PHASE),
        .CYCLE_HALF_WAIT (CYCLE_HALF_WAIT),
        .TIMER_WID       (TIMER_WID)
    ) u_rx (
        .clk     (clk),
        .rst_L   (rst_L),
        .i_start (w_start),
        .i_abort (w_abort),
        .i_miso  (miso),
        .o_sck   (sck),
        .o_done  (w_done),
        .o_data  (w_shift)
    );

    // Request handshake, conversion wait and slave-select framing; dropping arm mid-transfer discards it
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            ss_L     <= 1'b1;
            busy     <= 1'b0;
            finished <= 1'b0;
            data     <= '0;
        end else if (w_abort) begin
            r_state  <= ST_IDLE;
            ss_L     <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (arm) begin
                    r_state <= ST_CONVERT;
                    r_timer <= '0;
                    ss_L    <= 1'b0;
                    busy    <= 1'b1;
                end
                ST_CONVERT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_start) r_state <= ST_SHIFT;
                end
                ST_SHIFT: if (w_done) begin
                    r_state  <= ST_DONE;
                    ss_L     <= 1'b1;
                    busy     <= 1'b0;
                    finished <= 1'b1;
                    data     <= w_shift;
                end
                ST_DONE: if (!arm) begin
                    r_state  <= ST_IDLE;
                    finished <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: four reader instances in different SPI modes, each with a behavioural ADC slave
module tb_adc_spi_reader;

    localparam int        W    = 18;
    localparam int        CW   = 150;
    localparam logic [3:0] POLV = 4'b1001;
    localparam logic [3:0] PHV  = 4'b1100;

    logic          clk = 1'b0;
    logic          rst_l = 1'b1;
    logic [3:0]    arm = '0;
    logic [W-1:0]  word [4];
    wire  [3:0]    finished;
    wire  [3:0]    busy;
    wire  [3:0]    sck;
    wire  [3:0]    ss_l;
    wire  [4*W-1:0] data_f;
    int            n_chk = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic P = POLV[g];
        localparam logic C = PHV[g];
        logic         miso = 1'b0;
        logic         ss_q = 1'b1;
        logic         sck_q = P;
        logic [W-1:0] sreg = '0;

        adc_spi_reader #(
            .POLARITY        (P ? 1 : 0),
            .PHASE           (C ? 1 : 0),
            .CYCLE_HALF_WAIT (g == 3 ? 3 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_L    (rst_l),
            .arm      (arm[g]),
            .finished (finished[g]),
            .data     (data_f[g*W +: W]),
            .busy     (busy[g]),
            .miso     (miso),
            .sck      (sck[g]),
            .ss_L     (ss_l[g])
        );

        // Slave: loads its word when selected, presents MSB first, advances on the mode's launch edge
        always @(ss_l[g] or sck[g]) begin
            if (ss_q && !ss_l[g]) begin
                sreg = word[g];
                if (!C) begin
                    miso = sreg[W-1];
                    sreg = sreg << 1;
                end else begin
                    miso = 1'b0;
                end
            end else if (!ss_l[g] && sck[g] !== sck_q && ((sck[g] !== P) == C)) begin
                miso = sreg[W-1];
                sreg = sreg << 1;
            end
            ss_q  = ss_l[g];
            sck_q = sck[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] dat(input int i);
        return data_f[i*W +: W];
    endfunction

    function automatic int hof(input int i);
        return (i == 3) ? 3 : 1;
    endfunction

    // One full conversion: the reference is the slave word, CW + 2*W*H low clocks, W pulses, H-clock half-periods
    task automatic xfer(input int i, input logic [W-1:0] w);
        int lo, lead, first_t, last_t;
        logic ps, done, half_ok, busy_ok, fin_ok, data_ok;
        logic [W-1:0] prev;
        prev    = dat(i);
        word[i] = w;
        check($sformatf("i%0d_idle_sck", i), sck[i], POLV[i]);
        arm[i]  = 1'b1;
        lo = 0; lead = 0; first_t = -1; last_t = -1; ps = sck[i];
        done = 0; half_ok = 1; busy_ok = 1; fin_ok = 1; data_ok = 1;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (!ss_l[i]) begin
                if (sck[i] !== ps) begin
                    if (sck[i] !== POLV[i]) lead++;
                    if (last_t < 0) first_t = lo;
                    else if (lo - last_t != hof(i)) half_ok = 0;
                    last_t = lo;
                end
                if (busy[i] !== 1'b1) busy_ok = 0;
                if (finished[i] !== 1'b0) fin_ok = 0;
                if (dat(i) !== prev) data_ok = 0;
                ps = sck[i];
                lo++;
            end else if (lo > 0) begin
                done = 1;
            end
        end
        check($sformatf("i%0d_timeout", i), done, 1);
        check($sformatf("i%0d_low_time", i), lo, CW + 2 * W * hof(i));
        check($sformatf("i%0d_pulses", i), lead, W);
        check($sformatf("i%0d_first_edge", i), first_t, CW);
        check($sformatf("i%0d_half_period", i), half_ok, 1);
        check($sformatf("i%0d_trail_hold", i), lo - last_t, hof(i));
        check($sformatf("i%0d_busy_low", i), busy_ok, 1);
        check($sformatf("i%0d_fin_early", i), fin_ok, 1);
        check($sformatf("i%0d_data_stable", i), data_ok, 1);
        check($sformatf("i%0d_fin_at_rise", i), finished[i], 1);
        check($sformatf("i%0d_busy_after", i), busy[i], 0);
        check($sformatf("i%0d_sck_after", i), sck[i], POLV[i]);
        check($sformatf("i%0d_data", i), dat(i), w);
    endtask

    task automatic release_arm(input int i);
        logic [W-1:0] d;
        d = dat(i);
        arm[i] = 1'b0;
        @(negedge clk);
        check($sformatf("i%0d_fin_clear", i), finished[i], 0);
        check($sformatf("i%0d_data_kept", i), dat(i), d);
    endtask

    initial begin
        logic [W-1:0] w2, prev;
        int lead;
        logic ps, fin_seen;
        for (int i = 0; i < 4; i++) word[i] = '0;
        #1 rst_l = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("i%0d_rst_ss", i), ss_l[i], 1);
            check($sformatf("i%0d_rst_sck", i), sck[i], POLV[i]);
            check($sformatf("i%0d_rst_fin", i), finished[i], 0);
            check($sformatf("i%0d_rst_busy", i), busy[i], 0);
            check($sformatf("i%0d_rst_data", i), dat(i), 0);
        end
        rst_l = 1'b1;
        @(negedge clk);

        xfer(0, 18'h2A5C3);
        release_arm(0);

        for (int i = 0; i < 4; i++) begin
            xfer(i, 18'h3FFFF);
            release_arm(i);
            xfer(i, 18'h00001);
            release_arm(i);
        end

        for (int i = 0; i < 4; i++) begin
            repeat (3) begin
                xfer(i, W'($urandom));
                release_arm(i);
            end
        end

        xfer(0, W'($urandom));
        fin_seen = 1;
        prev = dat(0);
        repeat (5) begin
            @(negedge clk);
            if (finished[0] !== 1'b1 || dat(0) !== prev || ss_l[0] !== 1'b1) fin_seen = 0;
        end
        check("hold_fin", fin_seen, 1);
        release_arm(0);
        w2 = W'($urandom) ^ prev;
        xfer(0, w2);
        release_arm(0);

        prev = dat(1);
        word[1] = ~prev;
        arm[1] = 1'b1;
        lead = 0;
        ps = sck[1];
        for (int c = 0; c < 1000 && lead < 7; c++) begin
            @(negedge clk);
            if (sck[1] !== ps && sck[1] !== POLV[1]) lead++;
            ps = sck[1];
        end
        check("ab_reach", lead, 7);
        check("ab_busy", busy[1], 1);
        arm[1] = 1'b0;
        @(negedge clk);
        check("ab_ss", ss_l[1], 1);
        check("ab_sck", sck[1], POLV[1]);
        check("ab_busy_off", busy[1], 0);
        fin_seen = 0;
        repeat (4) begin
            if (finished[1] !== 1'b0) fin_seen = 1;
            @(negedge clk);
        end
        check("ab_no_fin", fin_seen, 0);
        check("ab_data", dat(1), prev);
        xfer(1, W'($urandom));
        release_arm(1);

        word[0] = W'($urandom);
        arm[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("rs_conv", ss_l[0], 0);
        check("rs_data_before", dat(0), w2);
        #2 rst_l = 1'b0;
        #1;
        check("rs_ss", ss_l[0], 1);
        check("rs_sck", sck[0], POLV[0]);
        check("rs_data", dat(0), 0);
        check("rs_busy", busy[0], 0);
        check("rs_fin", finished[0], 0);
        arm[0] = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        xfer(0, W'($urandom));
        release_arm(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
